// File: rtl/norm_pkg.sv
// Shared widths, state encoding and exponent limits for the post-add normalization controller.
package norm_pkg;

    localparam int unsigned MANT_W = 26;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned LSH_W  = 5;

    localparam int unsigned FLAG_ZERO      = 0;
    localparam int unsigned FLAG_OVERFLOW  = 1;
    localparam int unsigned FLAG_UNDERFLOW = 2;

    localparam logic [EXP_W-1:0] EXP_MAX_NORMAL = 8'd254;
    localparam logic [EXP_W-1:0] EXP_INF        = 8'd255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StNorm = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/norm_lzc26.sv
// Distance from the leading one of a 26-bit sum mantissa down to the hidden-bit position (bit 24).
module norm_lzc26
    import norm_pkg::*;
(
    input  logic [MANT_W-1:0] m,
    output logic [LSH_W-1:0]  lz
);

    // Ascending scan: the highest set bit below 24 writes last and wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < 24; i++) begin
            if (m[i]) begin
                lz = LSH_W'(24 - i);
            end
        end
        if (m[24] || m[25]) begin
            lz = '0;
        end
    end

endmodule

// File: rtl/norm_sequencer.sv
// Post-add normalization FSM: carry right-shift, bounded left shifts, zero/overflow/underflow.
module norm_sequencer
    import norm_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic              in_sign,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] out_frac,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic [LSH_W-1:0]  out_lsh,
    output logic [2:0]        out_flags
);

    localparam logic [LSH_W-1:0] STEP_SH = LSH_W'(STEP);

    state_t              state_q, state_d;
    logic [MANT_W-1:0]   m_q, m_d;
    logic [EXP_W-1:0]    e_q, e_d;
    logic                sign_q, sign_d;
    logic [LSH_W-1:0]    lsh_q, lsh_d;
    logic [2:0]          flags_q, flags_d;
    logic                valid_q, valid_d;
    logic [LSH_W-1:0]    lz;
    logic [LSH_W-1:0]    sh;

    norm_lzc26 u_lzc (
        .m  (m_q),
        .lz (lz)
    );

    assign sh = (lz < STEP_SH) ? lz : STEP_SH;

    // Exponent updates are guarded (e < 254 before +1, e > sh before -sh) so 8 bits never wrap.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        e_d     = e_q;
        sign_d  = sign_q;
        lsh_d   = lsh_q;
        flags_d = flags_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    m_d     = in_mant;
                    e_d     = in_exp;
                    sign_d  = in_sign;
                    lsh_d   = '0;
                    flags_d = '0;
                    state_d = StNorm;
                end
            end
            StNorm: begin
                if (m_q == '0) begin
                    flags_d[FLAG_ZERO] = 1'b1;
                    e_d                = '0;
                    state_d            = StDone;
                    valid_d            = 1'b1;
                end else if (m_q[25]) begin
                    if (e_q >= EXP_MAX_NORMAL) begin
                        flags_d[FLAG_OVERFLOW] = 1'b1;
                        e_d                    = EXP_INF;
                        m_d                    = '0;
                    end else begin
                        m_d = m_q >> 1;
                        e_d = e_q + 8'd1;
                    end
                    state_d = StDone;
                    valid_d = 1'b1;
                end else if (m_q[24]) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                end else if (e_q <= {3'b000, sh}) begin
                    flags_d[FLAG_UNDERFLOW] = 1'b1;
                    e_d                     = '0;
                    m_d                     = '0;
                    state_d                 = StDone;
                    valid_d                 = 1'b1;
                end else begin
                    m_d   = m_q << sh;
                    e_d   = e_q - {3'b000, sh};
                    lsh_d = lsh_q + sh;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        if (flush) begin
            state_d = StIdle;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            e_q     <= '0;
            sign_q  <= 1'b0;
            lsh_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            sign_q  <= sign_d;
            lsh_q   <= lsh_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = valid_q;
    assign out_frac  = m_q[FRAC_W:1];
    assign out_exp   = e_q;
    assign out_sign  = sign_q;
    assign out_lsh   = lsh_q;
    assign out_flags = flags_q;

endmodule
